shift_sequencer: RTL and testbench
==================================

// Module: shift_sequencer
// PURPOSE
//   Multi-cycle 8-bit barrel-shift controller. Accepts one shift request, then
//   drives a single registered rank of 2:1 byte muxes through SHW stages, one stage
//   per cycle, stage k shifting by 2^k when shamt[k]=1. Reuses one mux rank for all
//   stages instead of an SHW-deep combinational shifter; sits between the issuing
//   control logic and the BARRELSHIFT result register.
// PARAMETERS
//   WIDTH  8  data width in bits; must equal 2**SHW
//   SHW    3  shift-amount width = number of sequenced stages
// PORTS
//   clk    in   1      single clock; all state changes on rising edge
//   rst    in   1      synchronous, active-high reset
//   start  in   1      request strobe; accepted only when ready=1
//   din    in   WIDTH  operand, sampled on accepted start
//   shamt  in   SHW    shift amount, sampled on accepted start
//   op     in   2      00 SLL, 01 SRL, 10 SRA, 11 ROR; sampled on accepted start
//   ready  out  1      1 in IDLE only
//   busy   out  1      1 in STAGE state
//   done   out  1      one-cycle pulse, result valid
//   dout   out  WIDTH  result; updated only when done=1, then held until next done
// BEHAVIOUR
//   Reset (sync, rst=1 at edge): state=IDLE, stage cnt=0, ready=1, busy=0,
//     done=0, dout=0, internal work reg/shamt/op regs=0. Reset mid-operation aborts;
//     no done pulse for the aborted request; dout forced to 0.
//   FSM: IDLE -> STAGE on start; STAGE loops cnt=0..SHW-1, -> DONE after cnt=SHW-1;
//     DONE -> IDLE unconditionally.
//   Accept cycle T (IDLE, start=1): work<=din, shamt_r<=shamt, op_r<=op, cnt<=0.
//   STAGE cycles T+1..T+SHW: if shamt_r[cnt] then work<=shift(work, 2^cnt, op_r)
//     else work<=work; cnt<=cnt+1.
//   DONE cycle T+SHW+1: done=1, dout=work. Fixed latency start->done = SHW+1 = 4
//     cycles, independent of shamt (shamt=0 still takes full latency, dout=din).
//   Shift rules per stage of distance d: SLL fill LSBs with 0; SRL fill MSBs with 0;
//     SRA fill MSBs with work[WIDTH-1] (sign of current work value, which equals
//     original sign); ROR bits leaving LSB re-enter at MSB. Composition of stages
//     equals single shift by shamt (0..WIDTH-1); no overflow/saturation.
//   start while ready=0 (STAGE or DONE) is ignored, not queued; din/shamt/op changes
//     during busy have no effect. Next accept earliest at T+SHW+2 (IDLE).
//   ready, busy, done are mutually exclusive, decoded from registered state only.
//   dout is registered and stable between done pulses; unaffected by ignored starts.
// TESTING
//   1 After rst: ready=1,busy=0,done=0,dout=8'h00; hold rst 1 cycle mid-op same.
//   2 SLL din=8'hB5 shamt=3 start@T -> busy T+1..T+3, done@T+4, dout=8'hA8.
//   3 SRA din=8'h96 shamt=2 -> dout=8'hE5; SRL din=8'hF0 shamt=7 -> dout=8'h01.
//   4 ROR din=8'h81 shamt=1 -> dout=8'hC0; shamt=0 any op -> dout=din, done@T+4.
//   5 start pulsed at T+2 with din=8'hFF during busy -> ignored; only one done,
//     result from first request; ready returns @T+5.
//   6 rst at T+2 of SLL request -> IDLE next cycle, no done, dout=0; new request
//     accepted immediately after reset completes with correct result.

Source files
------------

// File: rtl/shift_sequencer.sv
// Multi-cycle barrel shifter: one registered rank of byte muxes reused across SHW
// stages, stage k shifting the work value by 2**k when the matching shamt bit is set.
module shift_sequencer #(
    parameter int WIDTH = 8,
    parameter int SHW   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    input  logic [SHW-1:0]   shamt,
    input  logic [1:0]       op,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout
);

    localparam int CW = (SHW > 1) ? $clog2(SHW) : 1;
    localparam logic [CW-1:0] LAST_STAGE = CW'(SHW - 1);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STAGE,
        S_DONE
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] work_reg, work_next;
    logic [SHW-1:0]   shamt_reg, shamt_next;
    logic [1:0]       op_reg, op_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [WIDTH-1:0] dout_reg, dout_next;

    // Candidate result of every stage distance; the active stage picks one by cnt.
    logic [WIDTH-1:0] stage_shift [SHW];
    logic [WIDTH-1:0] stage_result;

    generate
        for (genvar gi = 0; gi < SHW; gi++) begin : g_stage
            localparam int D = 2 ** gi;
            logic [WIDTH-1:0] sll_val, srl_val, sra_val, ror_val;

            assign sll_val = work_reg << D;
            assign srl_val = work_reg >> D;
            assign sra_val = WIDTH'($signed(work_reg) >>> D);
            assign ror_val = (work_reg >> D) | (work_reg << (WIDTH - D));

            always_comb begin
                stage_shift[gi] = sll_val;
                case (op_reg)
                    OP_SLL:  stage_shift[gi] = sll_val;
                    OP_SRL:  stage_shift[gi] = srl_val;
                    OP_SRA:  stage_shift[gi] = sra_val;
                    OP_ROR:  stage_shift[gi] = ror_val;
                    default: stage_shift[gi] = sll_val;
                endcase
            end
        end
    endgenerate

    assign stage_result = shamt_reg[cnt_reg] ? stage_shift[cnt_reg] : work_reg;

    always_comb begin
        state_next = state_reg;
        work_next  = work_reg;
        shamt_next = shamt_reg;
        op_next    = op_reg;
        cnt_next   = cnt_reg;
        dout_next  = dout_reg;
        ready      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;

        case (state_reg)
            S_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    work_next  = din;
                    shamt_next = shamt;
                    op_next    = op;
                    cnt_next   = '0;
                    state_next = S_STAGE;
                end
            end
            S_STAGE: begin
                busy      = 1'b1;
                work_next = stage_result;
                cnt_next  = cnt_reg + 1'b1;
                // The final stage result goes straight into dout so it is valid with done.
                if (cnt_reg == LAST_STAGE) begin
                    cnt_next   = '0;
                    dout_next  = stage_result;
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            work_reg  <= '0;
            shamt_reg <= '0;
            op_reg    <= '0;
            cnt_reg   <= '0;
            dout_reg  <= '0;
        end else begin
            state_reg <= state_next;
            work_reg  <= work_next;
            shamt_reg <= shamt_next;
            op_reg    <= op_next;
            cnt_reg   <= cnt_next;
            dout_reg  <= dout_next;
        end
    end

    assign dout = dout_reg;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: latency, per-op results, ignored starts and
// mid-operation reset, all against hand-computed expectations.
module tb_shift_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] din;
    logic [2:0] shamt;
    logic [1:0] op;
    logic       ready, busy, done;
    logic [7:0] dout;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] last_dout;

    shift_sequencer #(.WIDTH(8), .SHW(3)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .din   (din),
        .shamt (shamt),
        .op    (op),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .dout  (dout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one request in the current IDLE cycle T and follows it to T+5.
    task automatic do_shift(input string tag, input logic [1:0] o, input logic [7:0] d,
                            input logic [2:0] s, input logic [7:0] exp);
        n_cmp++;
        if (ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s ready_before: got %b want 1", tag, ready);
        end
        start = 1'b1; din = d; shamt = s; op = o;
        for (int c = 1; c <= 3; c++) begin
            tick();
            start = 1'b0; din = 8'($urandom); shamt = 3'($urandom); op = 2'($urandom);
            n_cmp++;
            if ({ready, busy, done} !== 3'b010 || dout !== last_dout) begin
                n_err++;
                $display("FAIL %s busy_T+%0d: got rbd=%b dout=%h want rbd=010 dout=%h",
                         tag, c, {ready, busy, done}, dout, last_dout);
            end
        end
        tick();
        n_cmp++;
        if ({ready, busy, done} !== 3'b001 || dout !== exp) begin
            n_err++;
            $display("FAIL %s done_T+4: got rbd=%b dout=%h want rbd=001 dout=%h",
                     tag, {ready, busy, done}, dout, exp);
        end
        tick();
        n_cmp++;
        if ({ready, busy, done} !== 3'b100 || dout !== exp) begin
            n_err++;
            $display("FAIL %s idle_T+5: got rbd=%b dout=%h want rbd=100 dout=%h",
                     tag, {ready, busy, done}, dout, exp);
        end
        last_dout = exp;
        $display("txn %s op=%0d din=%h shamt=%0d dout=%h expected=%h", tag, o, d, s, dout, exp);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; din = 8'h00; shamt = 3'd0; op = 2'd0;
        tick(); tick();
        rst = 1'b0;
        n_cmp++;
        if ({ready, busy, done} !== 3'b100 || dout !== 8'h00) begin
            n_err++;
            $display("FAIL reset_state: got rbd=%b dout=%h want rbd=100 dout=00",
                     {ready, busy, done}, dout);
        end
        last_dout = 8'h00;
        $display("txn reset rbd=%b dout=%h", {ready, busy, done}, dout);
    endtask

    task automatic test_sll();
        do_shift("sll_b5_3", 2'b00, 8'hB5, 3'd3, 8'hA8);
        do_shift("sll_01_7", 2'b00, 8'h01, 3'd7, 8'h80);
    endtask

    task automatic test_srl_sra();
        do_shift("sra_96_2", 2'b10, 8'h96, 3'd2, 8'hE5);
        do_shift("srl_f0_7", 2'b01, 8'hF0, 3'd7, 8'h01);
        do_shift("sra_70_6", 2'b10, 8'h70, 3'd6, 8'h01);
    endtask

    task automatic test_ror_zero();
        do_shift("ror_81_1", 2'b11, 8'h81, 3'd1, 8'hC0);
        do_shift("ror_2d_5", 2'b11, 8'h2D, 3'd5, 8'h69);
        do_shift("sra_9c_0", 2'b10, 8'h9C, 3'd0, 8'h9C);
        do_shift("ror_5a_0", 2'b11, 8'h5A, 3'd0, 8'h5A);
    endtask

    task automatic test_back_to_back();
        do_shift("b2b_sll", 2'b00, 8'h3C, 3'd1, 8'h78);
        do_shift("b2b_srl", 2'b01, 8'h3C, 3'd2, 8'h0F);
    endtask

    task automatic test_ignored_start();
        logic [2:0] seen;
        // SRL C3 by 4 -> 0C; a second start with FF at T+2 must be dropped.
        start = 1'b1; din = 8'hC3; shamt = 3'd4; op = 2'b01;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1; din = 8'hFF; shamt = 3'd1; op = 2'b00;
        tick();
        start = 1'b0;
        n_cmp++;
        if ({ready, busy, done} !== 3'b010) begin
            n_err++;
            $display("FAIL ign_busy_T+3: got rbd=%b want 010", {ready, busy, done});
        end
        tick();
        n_cmp++;
        if (done !== 1'b1 || dout !== 8'h0C) begin
            n_err++;
            $display("FAIL ign_done_T+4: got done=%b dout=%h want done=1 dout=0c", done, dout);
        end
        tick();
        n_cmp++;
        if ({ready, busy, done} !== 3'b100) begin
            n_err++;
            $display("FAIL ign_ready_T+5: got rbd=%b want 100", {ready, busy, done});
        end
        seen = 3'b000;
        for (int c = 0; c < 6; c++) begin
            tick();
            seen = seen | {ready, busy, done} ^ 3'b100;
        end
        n_cmp++;
        if (seen !== 3'b000 || dout !== 8'h0C) begin
            n_err++;
            $display("FAIL ign_no_second: got activity=%b dout=%h want activity=000 dout=0c",
                     seen, dout);
        end
        last_dout = 8'h0C;
        $display("txn ignored_start dout=%h expected=0c", dout);
    endtask

    task automatic test_mid_reset();
        start = 1'b1; din = 8'h0F; shamt = 3'd2; op = 2'b00;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if ({ready, busy, done} !== 3'b100 || dout !== 8'h00) begin
            n_err++;
            $display("FAIL midrst_idle: got rbd=%b dout=%h want rbd=100 dout=00",
                     {ready, busy, done}, dout);
        end
        last_dout = 8'h00;
        $display("txn mid_reset rbd=%b dout=%h", {ready, busy, done}, dout);
        do_shift("after_rst", 2'b00, 8'h0F, 3'd2, 8'h3C);
    endtask

    initial begin
        test_reset();
        test_sll();
        test_srl_sra();
        test_ror_zero();
        test_back_to_back();
        test_ignored_start();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
